mem_arbiter: RTL and testbench



---
 rtl/core_mem_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and AXI constants for the core memory arbiter.
package core_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_PROT_NONE  = 3'd0;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 master between the
// instruction-fetch (read only) and load/store requesters.
module mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28
) (
  input  logic                          CLK,
  input  logic                          RSTN,

  input  logic                          I_REQ,
  input  logic [31:0]                   I_ADDR,
  output logic [C_AXI_DATA_WIDTH-1:0]   I_RDATA,
  output logic                          I_DONE,

  input  logic                          D_REQ,
  input  logic                          D_WE,
  input  logic [31:0]                   D_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   D_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] D_STRB,
  output logic [C_AXI_DATA_WIDTH-1:0]   D_RDATA,
  output logic                          D_DONE,

  output logic                          BUSY,
  output logic                          ERR,

  output logic [C_OFFSET_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,

  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,

  output logic [C_OFFSET_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,

  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,

  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  state_e                          state_q, state_d;
  gnt_e                            id_q, id_d;
  gnt_e                            last_gnt_q, last_gnt_d;
  gnt_e                            gnt;
  logic [C_OFFSET_WIDTH-1:0]       addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [C_AXI_DATA_WIDTH/8-1:0]   strb_q, strb_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            err_q, err_d;
  logic [C_AXI_DATA_WIDTH-1:0]     i_rdata_q, i_rdata_d;
  logic [C_AXI_DATA_WIDTH-1:0]     d_rdata_q, d_rdata_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      id_q       <= GNT_I;
      last_gnt_q <= GNT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_q      <= err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_d      = err_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    gnt        = GNT_I;

    unique case (state_q)
      ST_IDLE: begin
        if (I_REQ || D_REQ) begin
          // On a tie the requester not served last wins.
          if (I_REQ && D_REQ) gnt = (last_gnt_q == GNT_I) ? GNT_D : GNT_I;
          else                gnt = D_REQ ? GNT_D : GNT_I;
          id_d      = gnt;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (gnt == GNT_D) begin
            addr_d  = D_ADDR[C_OFFSET_WIDTH-1:0];
            wdata_d = D_WDATA;
            strb_d  = D_STRB;
            state_d = D_WE ? ST_WREQ : ST_RADDR;
          end else begin
            addr_d  = I_ADDR[C_OFFSET_WIDTH-1:0];
            state_d = ST_RADDR;
          end
        end
      end
      ST_RADDR: if (M_AXI_ARREADY) state_d = ST_RDATA;
      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          if (id_q == GNT_D) d_rdata_d = M_AXI_RDATA;
          else               i_rdata_d = M_AXI_RDATA;
          err_d   = err_q | (M_AXI_RRESP != AXI_RESP_OKAY);
          state_d = ST_RESP;
        end
      end
      ST_WREQ: begin
        aw_done_d = aw_done_q | M_AXI_AWREADY;
        w_done_d  = w_done_q  | M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          err_d   = err_q | (M_AXI_BRESP != AXI_RESP_OKAY);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_gnt_d = id_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is a decode of registered state only.
  assign M_AXI_ARVALID = (state_q == ST_RADDR);
  assign M_AXI_RREADY  = (state_q == ST_RDATA);
  assign M_AXI_AWVALID = (state_q == ST_WREQ) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == ST_WREQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == ST_WRESP);
  assign I_DONE        = (state_q == ST_RESP) && (id_q == GNT_I);
  assign D_DONE        = (state_q == ST_RESP) && (id_q == GNT_D);
  assign BUSY          = (state_q != ST_IDLE);
  assign ERR           = err_q;
  assign I_RDATA       = i_rdata_q;
  assign D_RDATA       = d_rdata_q;

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = strb_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_ARLEN   = AXI_LEN_SINGLE;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARPROT  = AXI_PROT_NONE;

  logic unused_ok;
  assign unused_ok = &{1'b0, M_AXI_RLAST, I_ADDR[31:C_OFFSET_WIDTH], D_ADDR[31:C_OFFSET_WIDTH]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: AXI slave RAM model with adjustable stalls and
// error injection, vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        I_REQ, I_DONE, D_REQ, D_WE, D_DONE, BUSY, ERR;
  logic [31:0] I_ADDR, I_RDATA, D_ADDR, D_WDATA, D_RDATA;
  logic [3:0]  D_STRB;
  logic [27:0] M_AXI_ARADDR, M_AXI_AWADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE, M_AXI_ARPROT;
  logic [1:0]  M_AXI_ARBURST, M_AXI_RRESP, M_AXI_BRESP;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [31:0] M_AXI_RDATA, M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;

  mem_arbiter #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(28)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_DONE(I_DONE),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_STRB(D_STRB),
    .D_RDATA(D_RDATA), .D_DONE(D_DONE), .BUSY(BUSY), .ERR(ERR),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AXI slave RAM model ----------------
  int          ar_lat = 0, aw_lat = 0, w_lat = 0;
  logic [1:0]  rresp_inj = 2'b00, bresp_inj = 2'b00;
  logic [31:0] mem [0:63];
  int          ar_cnt, aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [27:0] aw_a, wa_now;
  logic [31:0] w_d, wd_now;
  logic [3:0]  w_s, ws_now;

  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_lat);
  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_lat);
  assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_lat);
  assign M_AXI_RLAST   = 1'b1;
  assign wa_now = aw_got ? aw_a : M_AXI_AWADDR;
  assign wd_now = w_got  ? w_d  : M_AXI_WDATA;
  assign ws_now = w_got  ? w_s  : M_AXI_WSTRB;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hA500_0000 | 32'(k);
      mem[0] <= 32'h3E80_0093;
      mem[4] <= 32'h0BAD_F00D;
      mem[8] <= 32'h1234_5678;
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
    end else begin
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt + 1  : 0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= mem[M_AXI_ARADDR[7:2]];
        M_AXI_RRESP  <= rresp_inj;
      end else if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin w_got <= 1'b1; w_d <= M_AXI_WDATA; w_s <= M_AXI_WSTRB; end
      if ((aw_got || (M_AXI_AWVALID && M_AXI_AWREADY)) && (w_got || (M_AXI_WVALID && M_AXI_WREADY))) begin
        for (int b = 0; b < 4; b++)
          if (ws_now[b]) mem[wa_now[7:2]][8*b +: 8] <= wd_now[8*b +: 8];
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= bresp_inj;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0;
      end
    end
  end

  logic [27:0] last_ar = '0, last_aw = '0;
  always @(posedge CLK) begin
    if (M_AXI_ARVALID && M_AXI_ARREADY) last_ar <= M_AXI_ARADDR;
    if (M_AXI_AWVALID && M_AXI_AWREADY) last_aw <= M_AXI_AWADDR;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic id; logic chk; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge CLK) begin
    if (RSTN && (I_DONE || D_DONE)) begin
      check("one_done_at_a_time", {31'b0, I_DONE & D_DONE}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", {30'b0, I_DONE, D_DONE}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_id", {31'b0, D_DONE}, {31'b0, mon_e.id});
        if (mon_e.chk) check("rdata", D_DONE ? D_RDATA : I_RDATA, mon_e.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic is_d; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] exp; int lat; int ar_l; int w_l;
  } vec_t;

  // Called at posedge+1 of an IDLE cycle; returns at the same point.
  task automatic run_vec(input vec_t v);
    int   t0, lat;
    logic done, rd;
    ar_lat = v.ar_l;
    w_lat  = v.w_l;
    rd = !v.is_d || !v.we;
    sb.push_back('{v.is_d, rd, v.exp});
    t0 = cyc;
    D_WE = v.we; D_WDATA = v.wdata; D_STRB = v.strb;
    if (v.is_d) begin D_REQ = 1'b1; D_ADDR = v.addr; end
    else        begin I_REQ = 1'b1; I_ADDR = v.addr; end
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      done = v.is_d ? D_DONE : I_DONE;
      if (done) break;
    end
    lat = cyc - t0;
    check("done_seen", {31'b0, done}, 32'd1);
    check("latency", 32'(lat), 32'(v.lat));
    if (rd) check("araddr", {4'b0, last_ar}, {4'b0, v.addr[27:0]});
    else    check("awaddr", {4'b0, last_aw}, {4'b0, v.addr[27:0]});
    @(posedge CLK); #1;
    I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    ar_lat = 0; w_lat = 0;
  endtask

  task automatic check_quiet(input string name);
    check(name, {23'b0, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
                 M_AXI_BREADY, I_DONE, D_DONE, BUSY, ERR}, 32'd0);
  endtask

  vec_t vecs [12];
  logic [11:0] m_a, m_b, m_c, m_d;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h3E80_0093, 3, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0BAD_F00D, 3, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3, 32'h0,         3, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h1234_BEEF, 3, 0, 0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hC, 32'h0,         3, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 32'hCAFE_0009, 3, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 32'hF000_0006, 32'h0,         4'h0, 32'hA500_0001, 3, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h3E80_0093, 5, 2, 0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_002C, 32'h1122_3344, 4'hF, 32'h0,         6, 0, 3};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_002C, 32'h0,         4'h0, 32'h1122_3344, 3, 0, 0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0,         3, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'hA500_000C, 3, 0, 0};

    RSTN = 1'b0; I_REQ = 1'b0; I_ADDR = '0; D_REQ = 1'b0; D_WE = 1'b0;
    D_ADDR = '0; D_WDATA = '0; D_STRB = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_quiet("reset_ctrl");
    check("reset_i_rdata", I_RDATA, 32'd0);
    check("reset_d_rdata", D_RDATA, 32'd0);
    @(negedge CLK) RSTN = 1'b1;
    @(posedge CLK); #1;
    check_quiet("idle_after_reset");
    check("tieoffs", {15'b0, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT, M_AXI_WLAST},
          {15'b0, 8'd0, 3'd2, 2'b01, 3'd0, 1'b1});

    // Both held from cycle 0: D, I, D again.
    sb.push_back('{1'b1, 1'b1, 32'h0BAD_F00D});
    sb.push_back('{1'b0, 1'b1, 32'h3E80_0093});
    sb.push_back('{1'b1, 1'b1, 32'h0BAD_F00D});
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h10; I_REQ = 1'b1; I_ADDR = 32'h0;
    m_a = '0; m_b = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      m_a = {D_DONE, m_a[11:1]};
      m_b = {I_DONE, m_b[11:1]};
    end
    @(posedge CLK); #1;
    D_REQ = 1'b0; I_REQ = 1'b0;
    check("tie_d_done_cycles", {20'b0, m_a}, 32'h808);
    check("tie_i_done_cycles", {20'b0, m_b}, 32'h080);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // AWREADY held off 5 cycles, WREADY immediate.
    aw_lat = 5;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h28; D_WDATA = 32'h55AA_55AA; D_STRB = 4'hF;
    m_a = '0; m_b = '0; m_c = '0; m_d = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      m_a = {M_AXI_AWVALID, m_a[11:1]};
      m_b = {M_AXI_WVALID,  m_b[11:1]};
      m_c = {M_AXI_BREADY,  m_c[11:1]};
      m_d = {D_DONE,        m_d[11:1]};
      if (D_DONE) begin @(posedge CLK); #1; D_REQ = 1'b0; D_WE = 1'b0; end
    end
    @(posedge CLK); #1;
    aw_lat = 0;
    check("skew_awvalid", {20'b0, m_a}, 32'h07E);
    check("skew_wvalid",  {20'b0, m_b}, 32'h002);
    check("skew_bready",  {20'b0, m_c}, 32'h080);
    check("skew_d_done",  {20'b0, m_d}, 32'h100);
    run_vec('{1'b0, 1'b0, 32'h0000_0028, 32'h0, 4'h0, 32'h55AA_55AA, 3, 0, 0});

    // Read error is sticky across later OKAY responses.
    rresp_inj = 2'b10;
    run_vec('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h3E80_0093, 3, 0, 0});
    rresp_inj = 2'b00;
    check("err_after_rresp", {31'b0, ERR}, 32'd1);
    run_vec('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0BAD_F00D, 3, 0, 0});
    check("err_sticky", {31'b0, ERR}, 32'd1);

    // Reset while waiting in RDATA.
    sb.push_back('{1'b0, 1'b1, 32'h0});
    I_REQ = 1'b1; I_ADDR = 32'h4;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_reset_rready", {31'b0, M_AXI_RREADY}, 32'd1);
    RSTN = 1'b0;
    sb.delete();
    #1;
    check_quiet("async_reset_outputs");
    I_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
    @(posedge CLK); #1;
    run_vec('{1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'hA500_0001, 3, 0, 0});
    check("err_clear_after_reset", {31'b0, ERR}, 32'd0);

    bresp_inj = 2'b11;
    run_vec('{1'b1, 1'b1, 32'h0000_0034, 32'h0, 4'hF, 32'h0, 3, 0, 0});
    bresp_inj = 2'b00;
    check("err_after_bresp", {31'b0, ERR}, 32'd1);

    repeat (2) @(posedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
